// File: rtl/music_pkg.sv
// music_pkg
// Shared definitions for the music score player: the playback state
// encoding, default parameter values and the duration value that marks
// the end of a score.
package music_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    PLAY  = 2'd3
  } state_t;

  localparam int DEFAULT_KEY_BITS       = 4;
  localparam int DEFAULT_TIME_BITS      = 4;
  localparam int DEFAULT_ADDRESS_BITS   = 5;
  localparam int DEFAULT_DEPTH          = 32;
  localparam int DEFAULT_TICKS_PER_UNIT = 2_500_000;

  // A stored duration of zero terminates the score.
  localparam int END_MARKER = 0;

endpackage

// File: rtl/score_ram.sv
// score_ram
// Simple dual-port synchronous RAM holding the score entries.
// One write port and one registered read port. A read and a write to the
// same address in the same cycle return the old contents (read-first).
// The array and the read register are not reset.
//
// Ports:
//   clk      - system clock, rising edge
//   wr_en    - write wr_data at wr_addr this cycle
//   wr_addr  - write address
//   wr_data  - entry to store
//   rd_en    - capture mem[rd_addr] into the read register this cycle
//   rd_addr  - read address
//   rd_data  - registered read data, valid the cycle after rd_en
module score_ram
  import music_pkg::*;
#(
  parameter int Width       = DEFAULT_KEY_BITS + DEFAULT_TIME_BITS,
  parameter int Depth       = DEFAULT_DEPTH,
  parameter int AddressBits = DEFAULT_ADDRESS_BITS
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [AddressBits-1:0] wr_addr,
  input  logic [Width-1:0]       wr_data,
  input  logic                   rd_en,
  input  logic [AddressBits-1:0] rd_addr,
  output logic [Width-1:0]       rd_data
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rd_data_q;

  // Both ports use non-blocking updates, so a same-address read in the
  // write cycle naturally sees the value from before the write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/music_score_player.sv
// music_score_player
// Score store and autonomous playback engine for the sound path. The host
// writes (key, duration) entries into the score RAM; after a Start pulse the
// engine steps through the entries from address 0, holding each key for
// duration x TicksPerUnit cycles, and either stops (Done pulse) or restarts
// at address 0 when it reaches an end marker or the last entry.
//
// Ports:
//   Clock        - system clock, rising edge
//   Reset        - asynchronous, active-low
//   WriteEnable  - store KeyInput/TimeInput at WriteAddress this cycle
//   WriteAddress - score write address
//   KeyInput     - key code to store
//   TimeInput    - duration to store, 0 marks the end of the score
//   Start        - one-cycle pulse, begin playback at address 0 (IDLE only)
//   Stop         - one-cycle pulse, abort playback without Done
//   Loop         - level, restart at address 0 at the end of the score
//   KeyOutput    - key currently (or most recently) playing
//   NoteValid    - KeyOutput is an active note
//   Busy         - playback in progress
//   Done         - one-cycle pulse on natural end of playback
//   PlayAddress  - address of the current entry
module music_score_player
  import music_pkg::*;
#(
  parameter int KeyBits      = DEFAULT_KEY_BITS,
  parameter int TimeBits     = DEFAULT_TIME_BITS,
  parameter int AddressBits  = DEFAULT_ADDRESS_BITS,
  parameter int Depth        = DEFAULT_DEPTH,
  parameter int TicksPerUnit = DEFAULT_TICKS_PER_UNIT
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   WriteEnable,
  input  logic [AddressBits-1:0] WriteAddress,
  input  logic [KeyBits-1:0]     KeyInput,
  input  logic [TimeBits-1:0]    TimeInput,
  input  logic                   Start,
  input  logic                   Stop,
  input  logic                   Loop,
  output logic [KeyBits-1:0]     KeyOutput,
  output logic                   NoteValid,
  output logic                   Busy,
  output logic                   Done,
  output logic [AddressBits-1:0] PlayAddress
);

  localparam int EntryBits = KeyBits + TimeBits;
  localparam int TickBits  = (TicksPerUnit > 1) ? $clog2(TicksPerUnit) : 1;

  localparam logic [TickBits-1:0]    TickLast    = TickBits'(TicksPerUnit - 1);
  localparam logic [AddressBits-1:0] LastAddress = AddressBits'(Depth - 1);
  localparam logic [TimeBits-1:0]    EndTime     = TimeBits'(END_MARKER);
  localparam logic [TimeBits-1:0]    LastUnit    = TimeBits'(1);

  state_t                 state_q, state_d;
  logic [AddressBits-1:0] play_addr_q, play_addr_d;
  logic [KeyBits-1:0]     key_q, key_d;
  logic                   note_valid_q, note_valid_d;
  logic                   done_q, done_d;
  logic [TickBits-1:0]    tick_q, tick_d;
  logic [TimeBits-1:0]    unit_q, unit_d;
  logic                   end_reached;

  logic [EntryBits-1:0]   ram_rd_data;
  logic [KeyBits-1:0]     ram_key;
  logic [TimeBits-1:0]    ram_time;

  // Entries are stored as {key, duration}.
  score_ram #(
    .Width       (EntryBits),
    .Depth       (Depth),
    .AddressBits (AddressBits)
  ) u_score_ram (
    .clk     (Clock),
    .wr_en   (WriteEnable),
    .wr_addr (WriteAddress),
    .wr_data ({KeyInput, TimeInput}),
    .rd_en   (state_q == FETCH),
    .rd_addr (play_addr_q),
    .rd_data (ram_rd_data)
  );

  assign ram_key  = ram_rd_data[EntryBits-1:TimeBits];
  assign ram_time = ram_rd_data[TimeBits-1:0];

  // Next-state logic. The end-of-score decision is shared by the end marker
  // in LOAD and the final unit of the last entry in PLAY; Stop is applied
  // last so it overrides both a simultaneous Start and an end decision.
  always_comb begin
    state_d      = state_q;
    play_addr_d  = play_addr_q;
    key_d        = key_q;
    note_valid_d = note_valid_q;
    done_d       = 1'b0;
    tick_d       = tick_q;
    unit_d       = unit_q;
    end_reached  = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d     = FETCH;
          play_addr_d = '0;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        if (ram_time == EndTime) begin
          end_reached = 1'b1;
        end else begin
          state_d      = PLAY;
          key_d        = ram_key;
          note_valid_d = 1'b1;
          unit_d       = ram_time;
          tick_d       = '0;
        end
      end
      PLAY: begin
        if (tick_q == TickLast) begin
          tick_d = '0;
          unit_d = unit_q - 1'b1;
          if (unit_q == LastUnit) begin
            note_valid_d = 1'b0;
            if (play_addr_q == LastAddress) begin
              end_reached = 1'b1;
            end else begin
              state_d     = FETCH;
              play_addr_d = play_addr_q + 1'b1;
            end
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (end_reached) begin
      note_valid_d = 1'b0;
      if (Loop) begin
        state_d     = FETCH;
        play_addr_d = '0;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    if (Stop) begin
      state_d      = IDLE;
      note_valid_d = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      play_addr_q  <= '0;
      key_q        <= '0;
      note_valid_q <= 1'b0;
      done_q       <= 1'b0;
      tick_q       <= '0;
      unit_q       <= '0;
    end else begin
      state_q      <= state_d;
      play_addr_q  <= play_addr_d;
      key_q        <= key_d;
      note_valid_q <= note_valid_d;
      done_q       <= done_d;
      tick_q       <= tick_d;
      unit_q       <= unit_d;
    end
  end

  assign KeyOutput   = key_q;
  assign NoteValid   = note_valid_q;
  assign Busy        = (state_q != IDLE);
  assign Done        = done_q;
  assign PlayAddress = play_addr_q;

endmodule

// File: tb/tb_music_score_player.sv
// tb_music_score_player
// Self-checking bench for music_score_player with TicksPerUnit=4 and a
// four-entry score. Each test task pushes the notes it expects onto a
// scoreboard queue; a monitor pops them as notes start and checks key,
// address, the gap before the note and the note length, and also checks
// every Done pulse.
module tb_music_score_player;

  localparam int KB  = 4;
  localparam int TB  = 4;
  localparam int AB  = 2;
  localparam int DEP = 4;
  localparam int TPU = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          WriteEnable;
  logic [AB-1:0] WriteAddress;
  logic [KB-1:0] KeyInput;
  logic [TB-1:0] TimeInput;
  logic          Start;
  logic          Stop;
  logic          Loop;
  logic [KB-1:0] KeyOutput;
  logic          NoteValid;
  logic          Busy;
  logic          Done;
  logic [AB-1:0] PlayAddress;

  // len 0 = do not check length (note cut short); gap -1 = do not check gap
  typedef struct {
    logic [KB-1:0] key;
    logic [AB-1:0] addr;
    int            len;
    int            gap;
  } note_t;

  note_t exp_q[$];

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;

  bit    prev_nv, prev_done, gap_valid, cur_valid;
  int    run_len, gap_cnt;
  note_t cur;

  music_score_player #(
    .KeyBits      (KB),
    .TimeBits     (TB),
    .AddressBits  (AB),
    .Depth        (DEP),
    .TicksPerUnit (TPU)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .WriteEnable  (WriteEnable),
    .WriteAddress (WriteAddress),
    .KeyInput     (KeyInput),
    .TimeInput    (TimeInput),
    .Start        (Start),
    .Stop         (Stop),
    .Loop         (Loop),
    .KeyOutput    (KeyOutput),
    .NoteValid    (NoteValid),
    .Busy         (Busy),
    .Done         (Done),
    .PlayAddress  (PlayAddress)
  );

  always #5 Clock = ~Clock;

  // Scoreboard consumer: tracks note boundaries and Done pulses.
  always @(negedge Clock) begin
    if (Reset !== 1'b1) begin
      prev_nv   = 1'b0;
      prev_done = 1'b0;
      gap_valid = 1'b0;
      cur_valid = 1'b0;
      run_len   = 0;
      gap_cnt   = 0;
    end else begin
      if (Done === 1'b1) begin
        done_cnt++;
        total++;
        if (Busy !== 1'b0) begin
          bad++;
          $display("[TB] FAIL done_busy: Busy=%b required 0", Busy);
        end
        total++;
        if (prev_done !== 1'b0) begin
          bad++;
          $display("[TB] FAIL done_width: Done high %0d cycles in a row, required 1", 2);
        end
      end
      if (NoteValid === 1'b1 && !prev_nv) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_note: key=%0d addr=%0d, none expected", KeyOutput, PlayAddress);
          cur_valid = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          cur_valid = 1'b1;
          total++;
          if (KeyOutput !== cur.key) begin
            bad++;
            $display("[TB] FAIL note_key: got %0d required %0d", KeyOutput, cur.key);
          end
          total++;
          if (PlayAddress !== cur.addr) begin
            bad++;
            $display("[TB] FAIL note_addr: got %0d required %0d", PlayAddress, cur.addr);
          end
          if (cur.gap >= 0) begin
            total++;
            if (!gap_valid || gap_cnt != cur.gap) begin
              bad++;
              $display("[TB] FAIL note_gap: got %0d required %0d", gap_valid ? gap_cnt : -1, cur.gap);
            end
          end
        end
        run_len   = 1;
        gap_valid = 1'b0;
      end else if (NoteValid === 1'b1) begin
        run_len++;
      end else if (prev_nv) begin
        if (cur_valid && cur.len > 0) begin
          total++;
          if (run_len != cur.len) begin
            bad++;
            $display("[TB] FAIL note_len: key=%0d held %0d cycles required %0d", cur.key, run_len, cur.len);
          end
        end
        cur_valid = 1'b0;
        gap_valid = 1'b1;
        gap_cnt   = 1;
      end else if (gap_valid) begin
        if (Busy === 1'b1) gap_cnt++;
        else gap_valid = 1'b0;
      end
      prev_nv   = (NoteValid === 1'b1);
      prev_done = (Done === 1'b1);
    end
  end

  function automatic note_t mk(input int key, input int addr, input int len, input int gap);
    note_t n;
    n.key  = KB'(key);
    n.addr = AB'(addr);
    n.len  = len;
    n.gap  = gap;
    return n;
  endfunction

  task automatic write_entry(input int addr, input int key, input int t);
    @(negedge Clock);
    WriteEnable  = 1'b1;
    WriteAddress = AB'(addr);
    KeyInput     = KB'(key);
    TimeInput    = TB'(t);
    @(negedge Clock);
    WriteEnable  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge Clock);
    Stop = 1'b1;
    @(negedge Clock);
    Stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clock);
      if (Busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_queue_empty(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clock);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    WriteEnable = 1'b0; WriteAddress = '0; KeyInput = '0; TimeInput = '0;
    Start = 1'b0; Stop = 1'b0; Loop = 1'b0;
    #2 Reset = 1'b0;
    repeat (2) @(negedge Clock);
    total++; if (KeyOutput !== 4'd0) begin bad++; $display("[TB] FAIL reset_key: got %0d required 0", KeyOutput); end
    total++; if (NoteValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b required 0", NoteValid); end
    total++; if (Busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b required 0", Busy); end
    total++; if (Done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b required 0", Done); end
    total++; if (PlayAddress !== 2'd0) begin bad++; $display("[TB] FAIL reset_addr: got %0d required 0", PlayAddress); end
    Reset = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_single_pass();
    int done_before;
    int lat;
    bit ok;
    write_entry(0, 3, 2);
    write_entry(1, 5, 1);
    write_entry(2, 0, 0);
    Loop = 1'b0;
    done_before = done_cnt;
    exp_q.push_back(mk(3, 0, 8, -1));
    exp_q.push_back(mk(5, 1, 4, 2));
    @(negedge Clock);
    Start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clock);
      Start = 1'b0;
      if (NoteValid === 1'b1) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat != 3) begin bad++; $display("[TB] FAIL start_latency: got %0d required 3", lat); end
    wait_idle(200, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL single_timeout: Busy=%b required 0", Busy); end
    @(negedge Clock);
    total++;
    if (done_cnt != done_before + 1) begin bad++; $display("[TB] FAIL single_done: got %0d pulses required 1", done_cnt - done_before); end
    total++;
    if (NoteValid !== 1'b0) begin bad++; $display("[TB] FAIL single_valid_end: got %b required 0", NoteValid); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL single_notes_left: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_loop();
    int done_before;
    bit ok;
    Loop = 1'b1;
    done_before = done_cnt;
    exp_q.push_back(mk(3, 0, 8, -1));
    exp_q.push_back(mk(5, 1, 4, 2));
    for (int p = 1; p < 6; p++) begin
      exp_q.push_back(mk(3, 0, 8, 4));
      exp_q.push_back(mk(5, 1, (p == 5) ? 0 : 4, 2));
    end
    pulse_start();
    wait_queue_empty(300, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL loop_timeout: %0d notes left required 0", exp_q.size()); end
    pulse_stop();
    total++;
    if (Busy !== 1'b0) begin bad++; $display("[TB] FAIL loop_stop_busy: got %b required 0", Busy); end
    repeat (3) @(negedge Clock);
    total++;
    if (done_cnt != done_before) begin bad++; $display("[TB] FAIL loop_done: got %0d pulses required 0", done_cnt - done_before); end
    Loop = 1'b0;
  endtask

  task automatic test_last_entry();
    int done_before;
    bit ok;
    write_entry(0, 1, 1);
    write_entry(1, 2, 1);
    write_entry(2, 4, 1);
    write_entry(3, 6, 1);
    Loop = 1'b0;
    done_before = done_cnt;
    exp_q.push_back(mk(1, 0, 4, -1));
    exp_q.push_back(mk(2, 1, 4, 2));
    exp_q.push_back(mk(4, 2, 4, 2));
    exp_q.push_back(mk(6, 3, 4, 2));
    pulse_start();
    wait_idle(200, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL last_timeout: Busy=%b required 0", Busy); end
    @(negedge Clock);
    total++;
    if (done_cnt != done_before + 1) begin bad++; $display("[TB] FAIL last_done: got %0d pulses required 1", done_cnt - done_before); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL last_notes_left: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_stop_start();
    int done_before;
    bit ok;
    write_entry(0, 3, 2);
    write_entry(1, 5, 1);
    write_entry(2, 0, 0);
    Loop = 1'b0;
    done_before = done_cnt;
    exp_q.push_back(mk(3, 0, 8, -1));
    exp_q.push_back(mk(5, 1, 0, 2));
    pulse_start();
    wait_queue_empty(100, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL stop_timeout: %0d notes left required 0", exp_q.size()); end
    @(negedge Clock);
    Stop  = 1'b1;
    Start = 1'b1;
    @(negedge Clock);
    Stop  = 1'b0;
    Start = 1'b0;
    total++;
    if (Busy !== 1'b0) begin bad++; $display("[TB] FAIL stop_busy: got %b required 0", Busy); end
    total++;
    if (NoteValid !== 1'b0) begin bad++; $display("[TB] FAIL stop_valid: got %b required 0", NoteValid); end
    repeat (20) @(negedge Clock);
    total++;
    if (done_cnt != done_before) begin bad++; $display("[TB] FAIL stop_done: got %0d pulses required 0", done_cnt - done_before); end
    total++;
    if (Busy !== 1'b0) begin bad++; $display("[TB] FAIL stop_stays_idle: Busy=%b required 0", Busy); end
    exp_q.push_back(mk(3, 0, 8, -1));
    exp_q.push_back(mk(5, 1, 4, 2));
    pulse_start();
    wait_idle(200, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL replay_timeout: Busy=%b required 0", Busy); end
    @(negedge Clock);
    total++;
    if (done_cnt != done_before + 1) begin bad++; $display("[TB] FAIL replay_done: got %0d pulses required 1", done_cnt - done_before); end
  endtask

  task automatic test_overwrite();
    bit ok;
    bit found;
    Loop = 1'b1;
    exp_q.push_back(mk(3, 0, 8, -1));
    exp_q.push_back(mk(5, 1, 4, 2));
    exp_q.push_back(mk(3, 0, 8, 4));
    exp_q.push_back(mk(9, 1, 0, 2));
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      if (Busy === 1'b1 && NoteValid === 1'b0 && PlayAddress === 2'd1) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin bad++; $display("[TB] FAIL overwrite_fetch_timeout: addr=%0d required 1", PlayAddress); end
    WriteEnable  = 1'b1;
    WriteAddress = 2'd1;
    KeyInput     = 4'd9;
    TimeInput    = 4'd1;
    @(negedge Clock);
    WriteEnable  = 1'b0;
    wait_queue_empty(200, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL overwrite_timeout: %0d notes left required 0", exp_q.size()); end
    pulse_stop();
    total++;
    if (Busy !== 1'b0) begin bad++; $display("[TB] FAIL overwrite_stop_busy: got %b required 0", Busy); end
    Loop = 1'b0;
  endtask

  task automatic test_reset_mid_note();
    int done_before;
    bit ok;
    bit seen;
    Loop = 1'b0;
    exp_q.push_back(mk(3, 0, 0, -1));
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (NoteValid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL midreset_note_timeout: NoteValid=%b required 1", NoteValid); end
    repeat (2) @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    total++; if (KeyOutput !== 4'd0) begin bad++; $display("[TB] FAIL midreset_key: got %0d required 0", KeyOutput); end
    total++; if (NoteValid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_valid: got %b required 0", NoteValid); end
    total++; if (Busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy: got %b required 0", Busy); end
    total++; if (PlayAddress !== 2'd0) begin bad++; $display("[TB] FAIL midreset_addr: got %0d required 0", PlayAddress); end
    @(negedge Clock);
    Reset = 1'b1;
    done_before = done_cnt;
    exp_q.push_back(mk(3, 0, 8, -1));
    exp_q.push_back(mk(9, 1, 4, 2));
    pulse_start();
    wait_idle(200, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL midreset_replay_timeout: Busy=%b required 0", Busy); end
    @(negedge Clock);
    total++;
    if (done_cnt != done_before + 1) begin bad++; $display("[TB] FAIL midreset_done: got %0d pulses required 1", done_cnt - done_before); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL midreset_notes_left: got %0d required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_loop();
    test_last_entry();
    test_stop_start();
    test_overwrite();
    test_reset_mid_note();
    repeat (2) @(negedge Clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/music_score_player.md
# music_score_player

Parametrised music-score store and playback engine for the Pong game's sound path. It holds a score of (key, duration) entries in on-chip RAM with a host write port, and plays the score autonomously: it steps through entries, holds each key for its duration in time units, and stops or loops at an end marker. Its key output drives the tone generator; the game FSM controls it with Start/Stop pulses.

## Interface
- KeyBits, 4, width of a key code (tone index)
- TimeBits, 4, width of a duration field, in time units
- AddressBits, 5, score address width
- Depth, 32, number of score entries (≤ 2**AddressBits)
- TicksPerUnit, 2_500_000, Clock cycles per time unit (≥ 1)

- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  asynchronous, active-low; clears all control state and outputs
- WriteEnable  in  1  write KeyInput/TimeInput at WriteAddress this cycle
- WriteAddress  in  AddressBits  score write address
- KeyInput  in  KeyBits  key to store
- TimeInput  in  TimeBits  duration to store; 0 = end marker
- Start  in  1  one-cycle pulse, begin playback at address 0
- Stop  in  1  one-cycle pulse, abort playback
- Loop  in  1  level; 1 = restart at address 0 on end marker / last entry
- KeyOutput  out  KeyBits  key currently playing
- NoteValid  out  1  KeyOutput is an active note
- Busy  out  1  playback in progress (any state but IDLE)
- Done  out  1  one-cycle pulse on natural end of playback (not on Stop)
- PlayAddress  out  AddressBits  address of the current entry

## Operation
- States: IDLE, FETCH, LOAD, PLAY.
- IDLE: Start → FETCH with PlayAddress=0. Start ignored in any other state.
- FETCH: RAM read issued at PlayAddress → LOAD.
- LOAD: entry captured. Time==0 → end: Loop=1 → FETCH at address 0; Loop=0 → IDLE, Done pulses. Time≠0 → PLAY, KeyOutput=key, unit counter=Time, tick counter=0.
- PLAY: tick counter counts 0..TicksPerUnit-1; on wrap, unit counter decrements; on the wrap that takes it to 0: if PlayAddress==Depth-1 treat as end (same Loop rule as end marker, Done pulses if Loop=0); else PlayAddress+1 → FETCH.
- Stop in any state → IDLE next cycle; Stop overrides a simultaneous Start or end. No Done.
- Loop is sampled at the end decision only.
- All-zero-duration score with Loop=1: FETCH/LOAD cycle forever, NoteValid stays 0 (legal, not guarded).
- Writes accepted in every state. Write and read to same address same cycle: read returns old data (read-first). Entries already captured are unaffected by later writes.
- RAM contents are not reset; undefined until written.
- Counters sized: tick counter ceil(log2(TicksPerUnit)) bits (min 1), unit counter TimeBits.

## Timing
- Reset values: KeyOutput=0, NoteValid=0, Busy=0, Done=0, PlayAddress=0, state IDLE.
- Start at cycle 0 → FETCH cycle 1, LOAD cycle 2, NoteValid=1 and KeyOutput valid from cycle 3.
- A note of duration T is held for exactly T×TicksPerUnit cycles with NoteValid=1.
- Between consecutive notes NoteValid=0 for exactly 2 cycles (FETCH, LOAD); KeyOutput holds the previous key.
- Done asserts in the cycle after the terminating LOAD/PLAY decision, coincident with Busy falling.
- Reset asserted mid-playback: outputs go to reset values immediately (asynchronous), RAM keeps contents.

## Structure
- Shared package music_pkg: state enum (IDLE, FETCH, LOAD, PLAY), default widths, END_MARKER=0 constant.
- One sub-module: score_ram — simple dual-port synchronous RAM (one write port, one registered read port, read-first), parameterised by KeyBits+TimeBits and Depth; no reset.
- Top holds FSM, tick/unit counters, address register and output registers.

## Test plan (TicksPerUnit=4)
- Write {key3,t2},{key5,t1},{key0,t0}; Start, Loop=0 → key 3 valid 8 cycles, 2-cycle gap, key 5 valid 4 cycles, Done one pulse, Busy falls, NoteValid=0.
- Same score, Loop=1 → sequence 3,5,3,5… with address returning to 0; no Done for 100 cycles.
- Depth=4, all four entries t1, no end marker, Loop=0 → addresses 0..3 played, Done after entry 3.
- Stop during key 5 with simultaneous Start → IDLE next cycle, NoteValid=0, no Done; later Start replays from address 0.
- Overwrite address 1 with {key9,t1} while address 1 is being fetched → old key 5 plays this pass; key 9 on the next looped pass.
- Reset low mid-note → all outputs 0 same cycle; after release, Start plays the unchanged RAM score.
